ex_div_unit: RTL and testbench
==============================

// Module: ex_div_unit
// PURPOSE
//  Iterative RV32M divider in the EX stage. Consumes the operand, rd and pc
//  outputs of the ID/EX pipeline register. Holds the pipeline via stall_o
//  while it iterates, then hands one result with done_o to the EX/MEM register.
//  Implements DIV, DIVU, REM and REMU with radix-2 restoring division.
// PARAMETERS
//  XLEN      32   operand/result width
//  CNT_W     6    iteration counter width, $clog2(XLEN)+1
// PORTS
//  clk       in   1     clock, rising edge
//  rst       in   1     reset, asynchronous, active-high
//  start_i   in   1     ID/EX holds a valid div/rem op this cycle
//  op_i      in   2     00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
//  rs1_i     in   XLEN  dividend (rs1_data_reg)
//  rs2_i     in   XLEN  divisor (rs2_data_reg)
//  rd_i      in   5     destination (rd_addr_ex)
//  pc_i      in   32    pc_EX, carried for trace/debug
//  flush_i   in   1     branch/trap kill of the EX-stage op
//  stall_o   out  1     hold IF/ID/EX registers this cycle
//  done_o    out  1     1-cycle pulse: result_o/rd_o/pc_o valid
//  result_o  out  XLEN  quotient or remainder
//  rd_o      out  5     destination of result
//  pc_o      out  32    pc of completing op
// BEHAVIOUR
//  Reset: state=IDLE; done_o=0; result_o=0; rd_o=0; pc_o=0; counter=0.
//  stall_o is combinational: (IDLE & start_i & ~flush_i) | (state==CALC).
//  The same op is held at the inputs while stalled.
//  FSM states:
//   IDLE: on start_i & ~flush_i, latch op, rd, pc and |rs1|/|rs2| magnitudes
//         (signed ops: two's-complement abs; negate flags = sign(rs1)^sign(rs2)
//         for the quotient and sign(rs1) for the remainder).
//         If rs2==0 or (signed & rs1==0x80000000 & rs2==-1), go to DONE
//         (special case). Otherwise go to CALC with counter=XLEN.
//   CALC: one quotient bit per cycle, MSB first. {rem,quo} shifts left;
//         rem-divisor computed on XLEN+1 bits; if non-negative, store it and set
//         quo[0]=1. counter decrements; at counter==1 go to DONE.
//   DONE: done_o=1 for exactly this cycle; result_o applies sign correction;
//         go to IDLE. stall_o=0, so the pipeline advances the same cycle.
//  Latency: start sampled in cycle T -> done_o in T+XLEN+1 (normal case),
//           or in T+1 (special case). No back-to-back overlap: a start_i
//           seen in DONE is ignored. The op still held in ID/EX during DONE
//           is the completing op and is not re-issued.
//  Special results:
//   div by 0: DIV/DIVU -> all ones (0xFFFFFFFF); REM/REMU -> rs1.
//   overflow (DIV only): 0x80000000; REM -> 0.
//  Remainder sign follows the dividend. Quotient truncates toward zero.
//  flush_i: in any state, go to IDLE next cycle; done_o stays 0 and no write
//   occurs. In IDLE, flush_i together with start_i does not start an op.
//  result_o, rd_o and pc_o hold their values after done_o falls, until the
//   next DONE. Mid-operation rst aborts immediately to reset values.
// TESTING
//  DIVU 100/7 -> done_o at T+33, result_o=14, rd_o=rd_i; stall_o high T..T+32.
//  REM -7/2 -> result_o=0xFFFFFFFF (-1); DIV -7/2 -> 0xFFFFFFFD (-3).
//  DIV 5/0 -> done_o at T+1, result 0xFFFFFFFF; REMU 5/0 -> 5; stall 1 cycle.
//  DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at T+1; REM same -> 0.
//  flush_i at T+10 of DIVU -> IDLE at T+11, no done_o, stall_o low from T+11.
//  rst asserted mid-CALC -> all outputs 0 at once; a new start runs a clean op.

Source files
------------

// File: rtl/ex_div_unit_if.sv
// ex_div_unit_if
//   Bundles the ID/EX-side request and the EX/MEM-side result of the
//   iterative divider into one interface.
//   Request (pipeline -> divider): start_i, op_i, rs1_i, rs2_i, rd_i, pc_i, flush_i
//   Result  (divider -> pipeline): stall_o, done_o, result_o, rd_o, pc_o
//   Debug   (divider -> observer): state_o, current FSM state encoding
//
// Handshake: start_i acts as "valid" and ~stall_o acts as "ready". A request
// is accepted on the rising edge where start_i=1, flush_i=0 and the divider is
// idle. The requester must hold op_i/rs1_i/rs2_i/rd_i/pc_i steady while
// stall_o=1. The result is presented for exactly one cycle with done_o=1 and
// has no back-pressure; result_o/rd_o/pc_o then hold until the next result.
interface ex_div_unit_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic [1:0]      op_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic [4:0]      rd_i;
    logic [31:0]     pc_i;
    logic            flush_i;
    logic            stall_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;
    logic [4:0]      rd_o;
    logic [31:0]     pc_o;
    logic [1:0]      state_o;

    modport master (
        output start_i, op_i, rs1_i, rs2_i, rd_i, pc_i, flush_i,
        input  stall_o, done_o, result_o, rd_o, pc_o, state_o
    );

    modport slave (
        input  start_i, op_i, rs1_i, rs2_i, rd_i, pc_i, flush_i,
        output stall_o, done_o, result_o, rd_o, pc_o, state_o
    );
endinterface

// File: rtl/ex_div_unit.sv
// ex_div_unit
//   Iterative RV32M divider for the EX stage (DIV, DIVU, REM, REMU) using
//   radix-2 restoring division, one quotient bit per cycle. It stalls the
//   pipeline while iterating and hands one result to EX/MEM with done_o.
// Ports
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : ex_div_unit_if.slave, request/result bundle plus debug state
module ex_div_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic          clk,
    input  logic          rst,
    ex_div_unit_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] ONE     = XLEN'(1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  quo_q;
    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  dvs_q;
    logic             rem_op_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic [4:0]       rd_q;
    logic [31:0]      pc_q;
    logic             done_q;
    logic [XLEN-1:0]  result_q;
    logic [4:0]       rd_out_q;
    logic [31:0]      pc_out_q;

    // Operand decode in IDLE: op_i[0]=1 means unsigned, op_i[1]=1 means remainder.
    logic            is_signed;
    logic            is_rem;
    logic            rs1_neg;
    logic            rs2_neg;
    logic [XLEN-1:0] rs1_abs;
    logic [XLEN-1:0] rs2_abs;
    logic            div_zero;
    logic            overflow;
    logic [XLEN-1:0] special_res;

    assign is_signed   = ~bus.op_i[0];
    assign is_rem      = bus.op_i[1];
    assign rs1_neg     = is_signed & bus.rs1_i[XLEN-1];
    assign rs2_neg     = is_signed & bus.rs2_i[XLEN-1];
    assign rs1_abs     = rs1_neg ? (~bus.rs1_i + ONE) : bus.rs1_i;
    assign rs2_abs     = rs2_neg ? (~bus.rs2_i + ONE) : bus.rs2_i;
    assign div_zero    = (bus.rs2_i == '0);
    assign overflow    = is_signed & (bus.rs1_i == INT_MIN) & (bus.rs2_i == '1);
    // Division by zero wins over overflow; remainder of x/0 is the raw dividend.
    assign special_res = div_zero ? (is_rem ? bus.rs1_i : '1)
                                  : (is_rem ? '0 : INT_MIN);

    // One restoring step. The partial remainder is shifted with the next
    // dividend bit and compared on XLEN+1 bits so a borrow shows as bit XLEN.
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] quo_n;
    logic [XLEN-1:0] rem_n;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;
    logic [XLEN-1:0] final_res;

    assign rem_sh    = {rem_q, quo_q[XLEN-1]};
    assign diff      = rem_sh - {1'b0, dvs_q};
    assign quo_n     = {quo_q[XLEN-2:0], ~diff[XLEN]};
    assign rem_n     = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
    assign quo_fix   = neg_quo_q ? (~quo_n + ONE) : quo_n;
    assign rem_fix   = neg_rem_q ? (~rem_n + ONE) : rem_n;
    assign final_res = rem_op_q ? rem_fix : quo_fix;

    // Stall in the accept cycle too, so ID/EX keeps the op for the next cycles.
    assign bus.stall_o  = ((state == IDLE) & bus.start_i & ~bus.flush_i) | (state == CALC);
    // A kill arriving in the DONE cycle must not let the result be written.
    assign bus.done_o   = done_q & ~bus.flush_i;
    assign bus.result_o = result_q;
    assign bus.rd_o     = rd_out_q;
    assign bus.pc_o     = pc_out_q;
    assign bus.state_o  = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            rem_op_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rd_q      <= '0;
            pc_q      <= '0;
            done_q    <= 1'b0;
            result_q  <= '0;
            rd_out_q  <= '0;
            pc_out_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start_i && !bus.flush_i) begin
                        rem_op_q  <= is_rem;
                        neg_quo_q <= rs1_neg ^ rs2_neg;
                        neg_rem_q <= rs1_neg;
                        rd_q      <= bus.rd_i;
                        pc_q      <= bus.pc_i;
                        quo_q     <= rs1_abs;
                        dvs_q     <= rs2_abs;
                        rem_q     <= '0;
                        if (div_zero || overflow) begin
                            done_q   <= 1'b1;
                            result_q <= special_res;
                            rd_out_q <= bus.rd_i;
                            pc_out_q <= bus.pc_i;
                            state    <= DONE;
                        end else begin
                            cnt   <= CNT_W'(XLEN);
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (bus.flush_i) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        quo_q <= quo_n;
                        rem_q <= rem_n;
                        cnt   <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            done_q   <= 1'b1;
                            result_q <= final_res;
                            rd_out_q <= rd_q;
                            pc_out_q <= pc_q;
                            state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    // A start seen here belongs to the completing op; ignore it.
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_div_unit.sv
module tb_ex_div_unit;
    localparam int XLEN = 32;
    localparam int W    = XLEN + 5 + 32;

    logic clk;
    logic rst;

    ex_div_unit_if #(.XLEN(XLEN)) bus ();

    ex_div_unit #(.XLEN(XLEN), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests_run = 0;
    int fails     = 0;

    logic [W-1:0]  exp_q[$];
    logic [31:0]   last_res;
    logic [4:0]    last_rd;
    logic [31:0]   last_pc;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
        case (op)
            2'b00:   return $signed(a) / $signed(b);
            2'b01:   return a / b;
            2'b10:   return $signed(a) % $signed(b);
            default: return a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // ---------------- driver ----------------
    task automatic drive_idle();
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        bus.op_i    = 2'b00;
        bus.rs1_i   = '0;
        bus.rs2_i   = '0;
        bus.rd_i    = '0;
        bus.pc_i    = '0;
    endtask

    task automatic drive_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd, input logic [31:0] pc);
        bus.op_i    = op;
        bus.rs1_i   = a;
        bus.rs2_i   = b;
        bus.rd_i    = rd;
        bus.pc_i    = pc;
        bus.start_i = 1'b1;
    endtask

    // Issue one op, hold it while stalled, check the result against the queue.
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] pc);
        int           exp_lat;
        bit           seen;
        bit           stall_bad;
        logic [W-1:0] exp_e;
        logic [W-1:0] got;
        seen      = 1'b0;
        stall_bad = 1'b0;
        exp_lat   = is_special(op, a, b) ? 1 : XLEN + 1;
        @(negedge clk);
        exp_q.push_back({ref_div(op, a, b), rd, pc});
        drive_op(op, a, b, rd, pc);
        #1;
        tests_run++;
        if (bus.stall_o !== 1'b1) begin
            fails++;
            $display("FAIL %s stall_at_accept got=%b want=1", name, bus.stall_o);
        end
        for (int k = 1; k <= XLEN + 8; k++) begin
            @(posedge clk);
            #1;
            if (bus.done_o === 1'b1) begin
                seen  = 1'b1;
                exp_e = exp_q.pop_front();
                got   = {bus.result_o, bus.rd_o, bus.pc_o};
                tests_run++;
                if (k != exp_lat) begin
                    fails++;
                    $display("FAIL %s latency got=%0d want=%0d", name, k, exp_lat);
                end
                tests_run++;
                if (got !== exp_e) begin
                    fails++;
                    $display("FAIL %s result got=%h rd=%0d pc=%h want=%h rd=%0d pc=%h", name,
                             got[W-1:37], got[36:32], got[31:0], exp_e[W-1:37], exp_e[36:32], exp_e[31:0]);
                end
                tests_run++;
                if (bus.stall_o !== 1'b0) begin
                    fails++;
                    $display("FAIL %s stall_in_done got=%b want=0", name, bus.stall_o);
                end
                last_res = exp_e[W-1:37];
                last_rd  = exp_e[36:32];
                last_pc  = exp_e[31:0];
                break;
            end else if (bus.stall_o !== 1'b1) begin
                stall_bad = 1'b1;
            end
        end
        tests_run++;
        if (!seen || stall_bad) begin
            fails++;
            $display("FAIL %s stall_or_timeout seen=%b stall_bad=%b want seen=1 stall_bad=0", name, seen, stall_bad);
            if (!seen && exp_q.size() > 0) void'(exp_q.pop_front());
        end
        @(negedge clk);
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if (bus.done_o !== 1'b0) begin
            fails++;
            $display("FAIL %s reissue done got=%b want=0", name, bus.done_o);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({bus.done_o, bus.stall_o, bus.result_o, bus.rd_o, bus.pc_o, bus.state_o} !== '0) begin
            fails++;
            $display("FAIL reset outputs done=%b stall=%b res=%h rd=%0d pc=%h st=%0d want all 0",
                     bus.done_o, bus.stall_o, bus.result_o, bus.rd_o, bus.pc_o, bus.state_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        run_op("divu_100_7",   2'b01, 32'd100,        32'd7,          5'd3,  32'h0000_1000);
        run_op("rem_m7_2",     2'b10, 32'hFFFF_FFF9,  32'd2,          5'd4,  32'h0000_1004);
        run_op("div_m7_2",     2'b00, 32'hFFFF_FFF9,  32'd2,          5'd5,  32'h0000_1008);
        run_op("div_5_0",      2'b00, 32'd5,          32'd0,          5'd6,  32'h0000_100C);
        run_op("remu_5_0",     2'b11, 32'd5,          32'd0,          5'd7,  32'h0000_1010);
        run_op("rem_m9_0",     2'b10, 32'hFFFF_FFF7,  32'd0,          5'd8,  32'h0000_1014);
        run_op("div_ovf",      2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  5'd9,  32'h0000_1018);
        run_op("rem_ovf",      2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  5'd10, 32'h0000_101C);
        run_op("divu_min_m1",  2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  5'd11, 32'h0000_1020);
        run_op("div_7_m2",     2'b00, 32'd7,          32'hFFFF_FFFE,  5'd12, 32'h0000_1024);
        run_op("rem_7_m2",     2'b10, 32'd7,          32'hFFFF_FFFE,  5'd13, 32'h0000_1028);
        run_op("rem_m7_m2",    2'b10, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  5'd14, 32'h0000_102C);
        run_op("divu_3_5",     2'b01, 32'd3,          32'd5,          5'd15, 32'h0000_1030);
        run_op("remu_max_10",  2'b11, 32'hFFFF_FFFF,  32'd10,         5'd16, 32'h0000_1034);
        run_op("divu_max_1",   2'b01, 32'hFFFF_FFFF,  32'd1,          5'd17, 32'h0000_1038);
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 20; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'($urandom_range(1, 15));
                1:       b = 32'($urandom_range(0, 3)) - 32'd2;
                default: b = $urandom;
            endcase
            run_op("random", op, a, b, 5'($urandom_range(1, 31)), $urandom);
        end
    endtask

    task automatic test_back_to_back();
        run_op("b2b_a", 2'b01, 32'd1000,       32'd33, 5'd20, 32'h0000_2000);
        run_op("b2b_b", 2'b00, 32'hFFFF_FC18,  32'd33, 5'd21, 32'h0000_2004);
        run_op("b2b_c", 2'b11, 32'd1000,       32'd33, 5'd22, 32'h0000_2008);
    endtask

    task automatic test_flush();
        bit done_seen;
        done_seen = 1'b0;
        @(negedge clk);
        drive_op(2'b01, 32'd1000, 32'd3, 5'd30, 32'h0000_3000);
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.flush_i = 1'b1;
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if (bus.stall_o !== 1'b0 || bus.done_o !== 1'b0 || bus.state_o !== 2'd0) begin
            fails++;
            $display("FAIL flush_idle stall=%b done=%b st=%0d want 0 0 0", bus.stall_o, bus.done_o, bus.state_o);
        end
        @(negedge clk);
        bus.flush_i = 1'b0;
        for (int k = 0; k < XLEN + 4; k++) begin
            @(posedge clk);
            #1;
            if (bus.done_o !== 1'b0) done_seen = 1'b1;
        end
        tests_run++;
        if (done_seen) begin
            fails++;
            $display("FAIL flush_no_done got done=1 want 0");
        end
        tests_run++;
        if ({bus.result_o, bus.rd_o, bus.pc_o} !== {last_res, last_rd, last_pc}) begin
            fails++;
            $display("FAIL flush_hold res=%h rd=%0d pc=%h want %h %0d %h",
                     bus.result_o, bus.rd_o, bus.pc_o, last_res, last_rd, last_pc);
        end
    endtask

    task automatic test_flush_start();
        @(negedge clk);
        drive_op(2'b01, 32'd9, 32'd3, 5'd31, 32'h0000_4000);
        bus.flush_i = 1'b1;
        #1;
        tests_run++;
        if (bus.stall_o !== 1'b0) begin
            fails++;
            $display("FAIL flush_start stall got=%b want=0", bus.stall_o);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (bus.done_o !== 1'b0 || bus.state_o !== 2'd0) begin
            fails++;
            $display("FAIL flush_start state done=%b st=%0d want 0 0", bus.done_o, bus.state_o);
        end
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_reset_mid();
        run_op("pre_reset", 2'b01, 32'd77, 32'd5, 5'd18, 32'h0000_5000);
        @(negedge clk);
        drive_op(2'b00, 32'd12345, 32'd17, 5'd19, 32'h0000_5004);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus.start_i = 1'b0;
        #1;
        tests_run++;
        if ({bus.done_o, bus.stall_o, bus.result_o, bus.rd_o, bus.pc_o, bus.state_o} !== '0) begin
            fails++;
            $display("FAIL reset_mid outputs done=%b stall=%b res=%h rd=%0d pc=%h st=%0d want all 0",
                     bus.done_o, bus.stall_o, bus.result_o, bus.rd_o, bus.pc_o, bus.state_o);
        end
        @(negedge clk);
        rst = 1'b0;
        run_op("post_reset", 2'b10, 32'd12345, 32'd17, 5'd19, 32'h0000_5008);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        last_res = '0;
        last_rd  = '0;
        last_pc  = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_flush();
        test_flush_start();
        test_reset_mid();
        tests_run++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
